// File: rtl/ballot_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ballot_pkg                                             |
// | Description : Shared types, constants and helpers for ballot_console |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package ballot_pkg;

  // Number of candidate buttons / width of the one-hot vote
  localparam int CAND_W = 4;

  // Console session state; 3 bits cover all six states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_SELECTED = 3'd2,
    ST_PRESENT  = 3'd3,
    ST_STROBE   = 3'd4,
    ST_RELEASE  = 3'd5
  } state_t;

  // True when exactly one bit of a candidate vector is set
  function automatic logic is_onehot4(input logic [CAND_W-1:0] v);
    return (v != '0) && ((v & (v - CAND_W'(1))) == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : debounce_sync                                          |
// | Description : 2-flop synchronizer + counting debounce filter with    |
// |               filtered level and rising-edge outputs                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module debounce_sync #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic f,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             s_q, s_d;
  logic             f_q, f_d;
  logic             f_dly_q, f_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Synchronize, then flip the filtered level only after a sustained difference
  always_comb begin
    sync1_d = raw;
    s_d     = sync1_q;
    f_dly_d = f_q;
    f_d     = f_q;
    cnt_d   = cnt_q;
    if (s_q == f_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      f_d   = s_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
      f_q     <= 1'b0;
      f_dly_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      s_q     <= s_d;
      f_q     <= f_d;
      f_dly_q <= f_dly_d;
      cnt_q   <= cnt_d;
    end
  end

  assign f    = f_q;
  assign rise = f_q & ~f_dly_q;

endmodule
`default_nettype wire

// File: rtl/ballot_console.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ballot_console                                         |
// | Description : Voter terminal: debounced keypad, officer-armed single |
// |               ballot, one-hot vote with setup/strobe/hold phases     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ballot_console
  import ballot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CONFIRM_HOLD    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  input  logic       cast_raw,
  input  logic       arm,
  output logic [3:0] vote_out,
  output logic       confirm_out,
  output logic [3:0] sel_led,
  output logic       armed,
  output logic       busy,
  output logic       multi_err,
  output logic [7:0] ballot_cnt
);

  localparam int NUM_IN = CAND_W + 1;
  localparam int HOLD_W = $clog2(CONFIRM_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CONFIRM_HOLD - 1);

  logic [NUM_IN-1:0] raw_all, f_all, rise_all;
  logic [CAND_W-1:0] btn_f, btn_rise;
  logic              cast_rise;

  // Candidates occupy the low bits, cast is the top bit
  assign raw_all = {cast_raw, btn_raw};

  generate
    for (genvar i = 0; i < NUM_IN; i++) begin : g_debounce
      debounce_sync #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (raw_all[i]),
        .f    (f_all[i]),
        .rise (rise_all[i])
      );
    end
  endgenerate

  assign btn_f     = f_all[CAND_W-1:0];
  assign btn_rise  = rise_all[CAND_W-1:0];
  // A rise already implies the filtered level is high; the AND keeps it explicit
  assign cast_rise = rise_all[CAND_W] & f_all[CAND_W];

  state_t            state_q, state_d;
  logic [CAND_W-1:0] sel_led_q, sel_led_d;
  logic [CAND_W-1:0] vote_q, vote_d;
  logic              confirm_q, confirm_d;
  logic              armed_q, armed_d;
  logic              busy_q, busy_d;
  logic              multi_err_q, multi_err_d;
  logic [7:0]        ballot_cnt_q, ballot_cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  // Session FSM; outputs are computed from the next state so they register with it
  always_comb begin
    state_d      = state_q;
    sel_led_d    = sel_led_q;
    multi_err_d  = 1'b0;
    ballot_cnt_d = ballot_cnt_q;
    hold_d       = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d   = ST_ARMED;
          sel_led_d = '0;
        end
      end
      ST_ARMED, ST_SELECTED: begin
        // Any candidate edge takes priority over cast, valid or not
        if (btn_rise != '0) begin
          if (is_onehot4(btn_rise) && is_onehot4(btn_f)) begin
            sel_led_d = btn_rise;
            state_d   = ST_SELECTED;
          end else begin
            multi_err_d = 1'b1;
          end
        end else if (cast_rise && (state_q == ST_SELECTED)) begin
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        state_d = ST_STROBE;
        hold_d  = '0;
      end
      ST_STROBE: begin
        if (hold_q == HOLD_LAST) begin
          state_d      = ST_RELEASE;
          ballot_cnt_d = ballot_cnt_q + 8'd1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_RELEASE: begin
        state_d   = ST_IDLE;
        sel_led_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    armed_d   = (state_d == ST_ARMED) || (state_d == ST_SELECTED);
    busy_d    = (state_d == ST_PRESENT) || (state_d == ST_STROBE) ||
                (state_d == ST_RELEASE);
    confirm_d = (state_d == ST_STROBE);
    vote_d    = busy_d ? sel_led_d : '0;
  end

  // Registered state and outputs; reset clears everything at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sel_led_q    <= '0;
      vote_q       <= '0;
      confirm_q    <= 1'b0;
      armed_q      <= 1'b0;
      busy_q       <= 1'b0;
      multi_err_q  <= 1'b0;
      ballot_cnt_q <= '0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      sel_led_q    <= sel_led_d;
      vote_q       <= vote_d;
      confirm_q    <= confirm_d;
      armed_q      <= armed_d;
      busy_q       <= busy_d;
      multi_err_q  <= multi_err_d;
      ballot_cnt_q <= ballot_cnt_d;
      hold_q       <= hold_d;
    end
  end

  assign vote_out    = vote_q;
  assign confirm_out = confirm_q;
  assign sel_led     = sel_led_q;
  assign armed       = armed_q;
  assign busy        = busy_q;
  assign multi_err   = multi_err_q;
  assign ballot_cnt  = ballot_cnt_q;

endmodule
`default_nettype wire

// File: doc/ballot_console.md
# ballot_console

Voter-side terminal that produces the one-hot vote and confirm strobe consumed by the tally machine's `voter[3:0]`/`confirm` inputs. It debounces four raw candidate buttons and a raw cast button, and lets a poll officer arm exactly one ballot per voter. It then presents the chosen one-hot code with clean setup, strobe and hold phases, so each armed session yields exactly one rising confirm edge. It sits between the physical keypad and the tally block's input pins.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized cycles an input must differ from its filtered value before the filtered value flips. Minimum 1; counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- `CONFIRM_HOLD`, default 2: cycles `confirm_out` stays high. Minimum 1.
- `clk`  in  1  single system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_raw`  in  4  raw candidate buttons, asynchronous, active-high.
- `cast_raw`  in  1  raw cast button, asynchronous, active-high.
- `arm`  in  1  officer arm pulse, synchronous to `clk`, single cycle.
- `vote_out`  out  4  one-hot vote to tally; 0 outside presentation.
- `confirm_out`  out  1  confirm strobe to tally.
- `sel_led`  out  4  current tentative selection (one-hot or 0).
- `armed`  out  1  high in ARMED or SELECTED.
- `busy`  out  1  high in PRESENT, STROBE or RELEASE.
- `multi_err`  out  1  one-cycle pulse on an ambiguous press.
- `ballot_cnt`  out  8  ballots issued by this console, wraps 255→0.

## Operation
- Input conditioning, per bit of `btn_raw` and `cast_raw`:
  - 2-flop synchronizer produces `s`.
  - Debounce counter: if `s==f`, counter←0. Else if counter==`DEBOUNCE_CYCLES`-1, then `f`←`s` and counter←0. Else counter increments.
  - A rising edge is `f & ~f_d`.
- FSM states: IDLE, ARMED, SELECTED, PRESENT, STROBE, RELEASE.
- IDLE:
  - `arm`=1 → ARMED, and `sel_led`←0.
  - Candidate and cast edges are ignored.
- ARMED or SELECTED, candidate edge:
  - Exactly one candidate rising edge and filtered `btn` has exactly one bit set → `sel_led`←that bit; state→SELECTED. Re-selection in SELECTED is allowed.
  - Otherwise (edges on ≥2 bits the same cycle, or ≥2 filtered bits high while an edge occurs) → `multi_err` pulses; selection and state are unchanged.
- SELECTED, cast edge: → PRESENT. If a valid candidate edge and a cast edge occur in the same cycle, the candidate update wins and cast is ignored.
- Cast edge in ARMED (no selection) is ignored.
- PRESENT: `vote_out`=`sel_led`, `confirm_out`=0, for 1 cycle → STROBE.
- STROBE: `vote_out` held and `confirm_out`=1 for exactly `CONFIRM_HOLD` cycles → RELEASE.
- RELEASE: `vote_out` held and `confirm_out`=0 for 1 cycle. On entry, `ballot_cnt` increments. On exit, `sel_led`←0 and state→IDLE.
- `arm` outside IDLE is ignored. It does not extend or restart a session.
- Buttons during PRESENT, STROBE and RELEASE are ignored; the debouncers keep running.
- Reset, including mid-presentation: every output goes to 0 immediately (asynchronously), and the FSM goes to IDLE. A truncated strobe is not replayed.

## Timing
- Reset values: `vote_out`=0, `confirm_out`=0, `sel_led`=0, `armed`=0, `busy`=0, `multi_err`=0, `ballot_cnt`=0. Synchronizer, filtered and counter registers are all 0.
- All outputs are registered; no combinational input-to-output path exists.
- Raw press held stable: `f` rises `DEBOUNCE_CYCLES`+2 cycles after the raw edge is first sampled. `sel_led` updates 1 cycle later.
- Cast edge → `vote_out` valid the next cycle.
- Vote stability around the strobe: `vote_out` is stable 1 cycle before `confirm_out` rises and 1 cycle after it falls.
- Session length from cast edge to IDLE: `CONFIRM_HOLD`+3 cycles.
- `armed` and `busy` reflect the registered state and change on the same edge as the state.

## Structure
- Shared package `ballot_pkg`:
  - FSM state enum.
  - `CAND_W`=4.
  - One-hot helper function `is_onehot4`.
- Sub-module `debounce_sync`: a parameterized single-bit synchronizer plus debounce filter with outputs `f` and `rise`. It is instantiated 5 times.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `CONFIRM_HOLD`=2.
- Basic vote: reset, then `arm`, then hold `btn_raw`=0100 for 10 cycles, then `cast_raw` for 10 cycles → `vote_out`=0100 for 4 cycles, with `confirm_out` high exactly cycles 2–3 of that window; `ballot_cnt`=1; return to IDLE.
- Bounce: `btn_raw[1]` toggles every 2 cycles for 20 cycles, then holds high → no selection during the toggling; `sel_led`=0010 exactly 7 cycles after the hold begins.
- Ambiguous press: in ARMED, `btn_raw`=0011 rising together → `multi_err` one pulse; `sel_led`=0; state stays ARMED.
- No arm: press candidate plus cast while IDLE → `vote_out`=0, `confirm_out` never rises, `ballot_cnt` unchanged.
- Re-select, then cast; re-arm during the strobe → final `vote_out` is the last selection; the mid-strobe `arm` is ignored; exactly one confirm rising edge.
- Reset mid-STROBE → all outputs 0 asynchronously. After 256 completed ballots, `ballot_cnt` wraps to 0.
